// File: rtl/sensor_conditioner_if.sv
// Signal bundle between the intersection sensors / traffic FSM and the sensor_conditioner.
// The master drives the raw sensors and ped_clr; the slave returns the conditioned levels.
interface sensor_conditioner_if;
  logic [3:0] car_raw;
  logic       button_raw;
  logic       ped_clr;
  logic       car1;
  logic       car2;
  logic       car3;
  logic       car4;
  logic       ped;
  logic [3:0] sensor_fault;

  modport master (
    output car_raw, button_raw, ped_clr,
    input  car1, car2, car3, car4, ped, sensor_fault
  );

  modport slave (
    input  car_raw, button_raw, ped_clr,
    output car1, car2, car3, car4, ped, sensor_fault
  );
endinterface

// File: rtl/sensor_conditioner.sv
// Synchronizes and debounces four car loops plus the pedestrian button, masks stuck loops,
// and holds the pedestrian request until the traffic FSM clears it.
module sensor_conditioner #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE     = 8,
  parameter int STUCK_CYCLES = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  sensor_conditioner_if.slave  bus
);
  localparam int NCH   = 5;
  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int STK_W = $clog2(STUCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE - 1);
  localparam logic [STK_W-1:0] STK_LIMIT = STK_W'(STUCK_CYCLES);

  logic [NCH-1:0]   sync_q [SYNC_STAGES];
  logic [NCH-1:0]   sync_d [SYNC_STAGES];
  logic [NCH-1:0]   db_q, db_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [STK_W-1:0] stk_q [4];
  logic [STK_W-1:0] stk_d [4];
  logic [3:0]       fault_q, fault_d;
  logic             db_btn_q, db_btn_d;
  logic             ped_q, ped_d;
  logic [NCH-1:0]   s;
  logic             rise;

  // Channel 4 is the button; channels 0..3 are car1..car4.
  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = {bus.button_raw, bus.car_raw};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    db_d = db_q;
    for (int c = 0; c < NCH; c++) begin
      cnt_d[c] = '0;
      if (s[c] != db_q[c]) begin
        if (cnt_q[c] == CNT_LAST) begin
          db_d[c] = s[c];
        end else begin
          cnt_d[c] = cnt_q[c] + 1'b1;
        end
      end
    end
  end

  // Stuck detector follows the next debounced level so the fault lands on the
  // STUCK_CYCLES-th edge counting the rising edge itself, and heals on the falling edge.
  always_comb begin
    fault_d = fault_q;
    for (int c = 0; c < 4; c++) begin
      stk_d[c] = stk_q[c];
      if (!db_d[c]) begin
        stk_d[c]   = '0;
        fault_d[c] = 1'b0;
      end else if (!fault_q[c]) begin
        stk_d[c] = stk_q[c] + 1'b1;
        if (stk_d[c] == STK_LIMIT) begin
          fault_d[c] = 1'b1;
        end
      end
    end
  end

  assign rise = db_q[4] & ~db_btn_q;

  always_comb begin
    db_btn_d = db_q[4];
    if (rise) begin
      ped_d = 1'b1;
    end else if (bus.ped_clr) begin
      ped_d = 1'b0;
    end else begin
      ped_d = ped_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c] <= '0;
      end
      for (int c = 0; c < 4; c++) begin
        stk_q[c] <= '0;
      end
      db_q     <= '0;
      fault_q  <= '0;
      db_btn_q <= 1'b0;
      ped_q    <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
      for (int c = 0; c < 4; c++) begin
        stk_q[c] <= stk_d[c];
      end
      db_q     <= db_d;
      fault_q  <= fault_d;
      db_btn_q <= db_btn_d;
      ped_q    <= ped_d;
    end
  end

  assign bus.car1         = db_q[0] & ~fault_q[0];
  assign bus.car2         = db_q[1] & ~fault_q[1];
  assign bus.car3         = db_q[2] & ~fault_q[2];
  assign bus.car4         = db_q[3] & ~fault_q[3];
  assign bus.ped          = ped_q;
  assign bus.sensor_fault = fault_q;
endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: directed scenarios with pinned edge expectations plus
// randomized raw activity, all compared every cycle against a behavioural model.
module tb_sensor_conditioner;
  localparam int SS    = 2;
  localparam int DB    = 8;
  localparam int STUCK = 64;

  logic clock = 1'b0;
  logic reset;

  sensor_conditioner_if bus();

  sensor_conditioner #(
    .SYNC_STAGES (SS),
    .DEBOUNCE    (DB),
    .STUCK_CYCLES(STUCK)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;

  // Behavioural model: delay line for the synchronizer, a window of recent samples per
  // channel (a level is accepted once the last DB samples all disagree with it), and a
  // count of edges each loop has spent debounced high.
  logic [4:0] m_sync [SS];
  logic [4:0] m_db;
  bit         hist [5][$];
  int         m_high [4];
  logic       m_btn_prev;
  logic       m_ped;

  always @(posedge clock) begin : model
    logic [4:0] s_old;
    logic       rise_m;
    bit         flip;
    if (reset) begin
      for (int i = 0; i < SS; i++) m_sync[i] = '0;
      for (int c = 0; c < 5; c++) hist[c].delete();
      for (int c = 0; c < 4; c++) m_high[c] = 0;
      m_db       = '0;
      m_btn_prev = 1'b0;
      m_ped      = 1'b0;
    end else begin
      s_old      = m_sync[SS-1];
      rise_m     = m_db[4] & ~m_btn_prev;
      m_ped      = rise_m | (m_ped & ~bus.ped_clr);
      m_btn_prev = m_db[4];
      for (int c = 0; c < 5; c++) begin
        hist[c].push_back(s_old[c]);
        if (hist[c].size() > DB) void'(hist[c].pop_front());
        flip = (hist[c].size() == DB);
        for (int k = 0; k < hist[c].size(); k++) begin
          if (hist[c][k] == m_db[c]) flip = 1'b0;
        end
        if (flip) begin
          m_db[c] = ~m_db[c];
          hist[c].delete();
        end
      end
      for (int c = 0; c < 4; c++) begin
        if (!m_db[c]) m_high[c] = 0;
        else if (m_high[c] < STUCK) m_high[c] = m_high[c] + 1;
      end
      for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = {bus.button_raw, bus.car_raw};
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic monitor();
    logic [3:0] ef, ec;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        for (int c = 0; c < 4; c++) begin
          ef[c] = m_db[c] && (m_high[c] >= STUCK);
          ec[c] = m_db[c] && !ef[c];
        end
        check("model car", {bus.car4, bus.car3, bus.car2, bus.car1}, ec);
        check("model fault", bus.sensor_fault, ef);
        check("model ped", {3'b0, bus.ped}, {3'b0, m_ped});
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [3:0] cars();
    return {bus.car4, bus.car3, bus.car2, bus.car1};
  endfunction

  initial begin
    reset          = 1'b1;
    bus.car_raw    = 4'hF;
    bus.button_raw = 1'b1;
    bus.ped_clr    = 1'b0;
    fork
      monitor();
    join_none

    // Reset held three edges with every raw input high.
    @(negedge clock);
    mon_en = 1'b1;
    check("reset cars", cars(), 4'h0);
    check("reset ped", {3'b0, bus.ped}, 4'h0);
    check("reset fault", bus.sensor_fault, 4'h0);
    step(2);
    reset = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      step(1);
      if (e == 9)  check("cars before edge 10", cars(), 4'h0);
      if (e == 10) begin
        check("cars at edge 10", cars(), 4'hF);
        check("ped before edge 11", {3'b0, bus.ped}, 4'h0);
      end
      if (e == 11) check("ped at edge 11", {3'b0, bus.ped}, 4'h1);
    end

    // Glitch rejection on car2 (pulse) and car3 (dropout).
    bus.car_raw    = 4'h0;
    bus.button_raw = 1'b0;
    step(12);
    bus.car_raw[2] = 1'b1;
    step(12);
    check("car3 settled", {3'b0, bus.car3}, 4'h1);
    bus.car_raw[1] = 1'b1;
    for (int e = 0; e < 34; e++) begin
      if (e == 5)  bus.car_raw[1] = 1'b0;
      if (e == 15) bus.car_raw[2] = 1'b0;
      if (e == 22) bus.car_raw[2] = 1'b1;
      step(1);
      if (e % 4 == 3) begin
        check("glitch car2", {3'b0, bus.car2}, 4'h0);
        check("dropout car3", {3'b0, bus.car3}, 4'h1);
      end
    end

    // Pedestrian latch with a clear while the button is still held.
    bus.car_raw = 4'h0;
    bus.ped_clr = 1'b1;
    step(1);
    bus.ped_clr = 1'b0;
    check("ped cleared", {3'b0, bus.ped}, 4'h0);
    step(12);
    bus.button_raw = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step(1);
      if (e == 19) bus.ped_clr = 1'b1;
      if (e == 20) bus.ped_clr = 1'b0;
      if (e == 10) check("ped before press edge 11", {3'b0, bus.ped}, 4'h0);
      if (e == 11) check("ped on press", {3'b0, bus.ped}, 4'h1);
      if (e == 19) check("ped held", {3'b0, bus.ped}, 4'h1);
      if (e == 20) check("ped clr edge 20", {3'b0, bus.ped}, 4'h0);
      if (e == 40) check("ped no reset while held", {3'b0, bus.ped}, 4'h0);
    end
    bus.button_raw = 1'b0;
    step(12);
    bus.button_raw = 1'b1;
    step(11);
    check("ped second press", {3'b0, bus.ped}, 4'h1);

    // Coincident rise and clear: set wins, then a held clear wins.
    bus.ped_clr = 1'b1;
    step(1);
    bus.ped_clr    = 1'b0;
    bus.button_raw = 1'b0;
    step(12);
    bus.button_raw = 1'b1;
    step(10);
    check("ped before coincident", {3'b0, bus.ped}, 4'h0);
    bus.ped_clr = 1'b1;
    step(1);
    check("ped set wins", {3'b0, bus.ped}, 4'h1);
    step(1);
    check("ped held clr", {3'b0, bus.ped}, 4'h0);
    bus.ped_clr = 1'b0;

    // Stuck car4 loop.
    bus.button_raw = 1'b0;
    step(15);
    bus.car_raw[3] = 1'b1;
    for (int e = 1; e <= 112; e++) begin
      step(1);
      if (e == 100) bus.car_raw[3] = 1'b0;
      if (e == 9)  check("car4 before edge 10", {3'b0, bus.car4}, 4'h0);
      if (e == 10) check("car4 edge 10", {3'b0, bus.car4}, 4'h1);
      if (e == 72) begin
        check("car4 edge 72", {3'b0, bus.car4}, 4'h1);
        check("fault edge 72", bus.sensor_fault, 4'h0);
      end
      if (e == 73) begin
        check("car4 masked edge 73", {3'b0, bus.car4}, 4'h0);
        check("fault edge 73", bus.sensor_fault, 4'h8);
      end
      if (e == 109) check("fault held edge 109", bus.sensor_fault, 4'h8);
      if (e == 110) check("fault healed edge 110", bus.sensor_fault, 4'h0);
      if (e == 100 || e == 110 || e == 112) check("car4 stays low", {3'b0, bus.car4}, 4'h0);
    end

    // Reset mid-debounce on car1 with ped set.
    bus.car_raw    = 4'h0;
    bus.button_raw = 1'b1;
    step(12);
    check("ped before mid reset", {3'b0, bus.ped}, 4'h1);
    bus.car_raw[0] = 1'b1;
    step(7);
    reset = 1'b1;
    step(1);
    check("mid reset cars", cars(), 4'h0);
    check("mid reset ped", {3'b0, bus.ped}, 4'h0);
    check("mid reset fault", bus.sensor_fault, 4'h0);
    reset = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      step(1);
      if (e == 9)  check("car1 restart before edge 10", cars(), 4'h0);
      if (e == 10) check("car1 restart edge 10", cars(), 4'h1);
      if (e == 11) check("ped after mid reset", {3'b0, bus.ped}, 4'h1);
    end

    // Randomized raw activity, including long holds and rare resets.
    for (int i = 0; i < 70; i++) begin
      int hold;
      hold = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 90)) : int'($urandom_range(1, 14));
      bus.car_raw    = 4'($urandom);
      bus.button_raw = 1'($urandom);
      for (int j = 0; j < hold; j++) begin
        bus.ped_clr = ($urandom_range(0, 7) == 0);
        reset       = ($urandom_range(0, 299) == 0);
        step(1);
      end
    end
    reset       = 1'b0;
    bus.ped_clr = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
